// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg -- shared definitions for the multiply/divide sequencer.
//   MD_WIDTH        default operand and HI/LO width
//   MD_MULT..DIVU   2-bit command encodings presented on op
//   md_state_e      sequencer state encoding
//   is_signed_op / is_div_op   command decode helpers
// -----------------------------------------------------------------------------
package md_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_if.sv
// -----------------------------------------------------------------------------
// md_if -- command / HI-LO bus between the core FSM and the md_ctrl sequencer.
//   master (core): drives start, op, a, b, wr_hi, wr_lo, wr_data;
//                  observes hi, lo, busy, done, illegal.
//   slave (md_ctrl): the mirror image.
// -----------------------------------------------------------------------------
interface md_if #(
    parameter int WIDTH = md_pkg::MD_WIDTH
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             illegal;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wr_data,
        input  hi, lo, busy, done, illegal
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wr_data,
        output hi, lo, busy, done, illegal
    );

endinterface

// File: rtl/md_step.sv
// -----------------------------------------------------------------------------
// md_step -- one combinational iteration on the {acc_hi, acc_lo} accumulator.
//   Multiply: add operand (multiplicand) to acc_hi when acc_lo[0] is set, then
//             shift the double-width accumulator right by one.
//   Divide (only with MD_DIV_EN defined): shift {rem, quo} left, trial-subtract
//             operand (divisor) from the remainder, keep it if non-negative
//             and shift in the quotient bit.
// Ports: div_mode (MD_DIV_EN builds only) selects divide; acc_hi/acc_lo are
//        the current accumulator halves; hi_nxt/lo_nxt the updated halves.
// -----------------------------------------------------------------------------
module md_step
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
`ifdef MD_DIV_EN
    input  logic             div_mode,
`endif
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0] mul_sum_s;

    // Multiply partial sum keeps its carry so the right shift loses nothing.
    always_comb begin
        if (acc_lo[0]) begin
            mul_sum_s = {1'b0, acc_hi} + {1'b0, operand};
        end else begin
            mul_sum_s = {1'b0, acc_hi};
        end
    end

`ifdef MD_DIV_EN
    logic [WIDTH:0]   div_sh_s;
    logic [WIDTH-1:0] div_diff_s;
    logic             div_ge_s;

    // Shifted remainder is one bit wider than the divisor; when it is not
    // smaller, the difference is below the divisor and fits in WIDTH bits.
    always_comb begin
        div_sh_s   = {acc_hi, acc_lo[WIDTH-1]};
        div_ge_s   = (div_sh_s >= {1'b0, operand});
        div_diff_s = div_sh_s[WIDTH-1:0] - operand;
    end

    // Select the multiply or divide update.
    always_comb begin
        hi_nxt = mul_sum_s[WIDTH:1];
        lo_nxt = {mul_sum_s[0], acc_lo[WIDTH-1:1]};
        if (div_mode) begin
            if (div_ge_s) begin
                hi_nxt = div_diff_s;
                lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = div_sh_s[WIDTH-1:0];
                lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt = mul_sum_s[WIDTH:1];
            lo_nxt = {mul_sum_s[0], acc_lo[WIDTH-1:1]};
        end
    end
`else
    // Multiply-only update.
    always_comb begin
        hi_nxt = mul_sum_s[WIDTH:1];
        lo_nxt = {mul_sum_s[0], acc_lo[WIDTH-1:1]};
    end
`endif

endmodule

// File: rtl/md_ctrl.sv
// -----------------------------------------------------------------------------
// md_ctrl -- multi-cycle multiply/divide sequencer owning the HI/LO pair.
// Ports:
//   clk, rst  core clock, asynchronous active-high reset
//   bus       md_if.slave: start/op/a/b command, wr_hi/wr_lo/wr_data for
//             mthi/mtlo, hi/lo architectural outputs, busy/done/illegal status
// Build option MD_DIV_EN: when defined, the divider and DIV state exist; when
// undefined, a divide command completes at once with done and illegal pulsed
// and HI/LO untouched.
// Operands are latched as magnitudes; the signs are re-applied in FIX.
// -----------------------------------------------------------------------------
module md_ctrl
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input logic clk,
    input logic rst,
    md_if.slave bus
);

    localparam int               CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + ONE_2W;
    endfunction

    md_state_e        state_r, state_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] acc_hi_r, acc_lo_r, opnd_r;
    logic             neg_q_r;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             busy_r, done_r, illegal_r;
    logic             illegal_s;

    logic             open_s, last_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic [WIDTH-1:0] step_hi_s, step_lo_s;
    logic [2*WIDTH-1:0] fix_prod_s;

`ifdef MD_DIV_EN
    logic             neg_rem_r;
    logic             is_div_r;
    logic             b_zero_s;
`endif

    // Command decode: operand magnitudes and FSM helper conditions.
    always_comb begin
        open_s  = (state_r == ST_IDLE) || (state_r == ST_DONE);
        last_s  = (cnt_r == LAST_CNT);
        a_neg_s = is_signed_op(bus.op) & bus.a[WIDTH-1];
        b_neg_s = is_signed_op(bus.op) & bus.b[WIDTH-1];
        a_mag_s = a_neg_s ? neg_w(bus.a) : bus.a;
        b_mag_s = b_neg_s ? neg_w(bus.b) : bus.b;
`ifdef MD_DIV_EN
        b_zero_s = (bus.b == {WIDTH{1'b0}});
`endif
        fix_prod_s = neg_q_r ? neg_2w({acc_hi_r, acc_lo_r}) : {acc_hi_r, acc_lo_r};
    end

    md_step #(.WIDTH(WIDTH)) u_step (
`ifdef MD_DIV_EN
        .div_mode (state_r == ST_DIV),
`endif
        .acc_hi   (acc_hi_r),
        .acc_lo   (acc_lo_r),
        .operand  (opnd_r),
        .hi_nxt   (step_hi_s),
        .lo_nxt   (step_lo_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE and DONE.
    always_comb begin
        state_s   = state_r;
        illegal_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    if (!is_div_op(bus.op)) begin
                        state_s = ST_MUL;
                    end else begin
`ifdef MD_DIV_EN
                        if (b_zero_s) begin
                            state_s = ST_FIX;
                        end else begin
                            state_s = ST_DIV;
                        end
`else
                        state_s   = ST_DONE;
                        illegal_s = 1'b1;
`endif
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (last_s) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_MUL;
                end
            end
`ifdef MD_DIV_EN
            ST_DIV: begin
                if (last_s) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_DIV;
                end
            end
`endif
            ST_FIX:  state_s = ST_DONE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Iteration counter: cleared while waiting, counts each MUL/DIV step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (open_s) begin
            cnt_r <= {CW{1'b0}};
        end else if ((state_r == ST_MUL) || (state_r == ST_DIV)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Operand latch on accept, accumulator update on every iteration.
    // Divide-by-zero preloads the final HI/LO values with no sign fix-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hi_r  <= {WIDTH{1'b0}};
            acc_lo_r  <= {WIDTH{1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            neg_q_r   <= 1'b0;
`ifdef MD_DIV_EN
            neg_rem_r <= 1'b0;
            is_div_r  <= 1'b0;
`endif
        end else if (open_s && bus.start) begin
`ifdef MD_DIV_EN
            is_div_r <= is_div_op(bus.op);
            if (is_div_op(bus.op) && b_zero_s) begin
                acc_hi_r  <= bus.a;
                acc_lo_r  <= {WIDTH{1'b1}};
                opnd_r    <= {WIDTH{1'b0}};
                neg_q_r   <= 1'b0;
                neg_rem_r <= 1'b0;
            end else if (is_div_op(bus.op)) begin
                acc_hi_r  <= {WIDTH{1'b0}};
                acc_lo_r  <= a_mag_s;
                opnd_r    <= b_mag_s;
                neg_q_r   <= a_neg_s ^ b_neg_s;
                neg_rem_r <= a_neg_s;
            end else begin
                acc_hi_r  <= {WIDTH{1'b0}};
                acc_lo_r  <= b_mag_s;
                opnd_r    <= a_mag_s;
                neg_q_r   <= a_neg_s ^ b_neg_s;
                neg_rem_r <= 1'b0;
            end
`else
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= b_mag_s;
            opnd_r   <= a_mag_s;
            neg_q_r  <= a_neg_s ^ b_neg_s;
`endif
        end else if ((state_r == ST_MUL) || (state_r == ST_DIV)) begin
            acc_hi_r <= step_hi_s;
            acc_lo_r <= step_lo_s;
        end
    end

    // Architectural HI/LO: result write in FIX, mthi/mtlo only while idle
    // and not coinciding with an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (state_r == ST_FIX) begin
`ifdef MD_DIV_EN
            if (is_div_r) begin
                lo_r <= neg_q_r   ? neg_w(acc_lo_r) : acc_lo_r;
                hi_r <= neg_rem_r ? neg_w(acc_hi_r) : acc_hi_r;
            end else begin
                {hi_r, lo_r} <= fix_prod_s;
            end
`else
            {hi_r, lo_r} <= fix_prod_s;
`endif
        end else if (open_s && !bus.start) begin
            if (bus.wr_hi) begin
                hi_r <= bus.wr_data;
            end
            if (bus.wr_lo) begin
                lo_r <= bus.wr_data;
            end
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            busy_r    <= (state_s == ST_MUL) || (state_s == ST_DIV) || (state_s == ST_FIX);
            done_r    <= (state_s == ST_DONE);
            illegal_r <= illegal_s;
        end
    end

    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.illegal = illegal_r;

endmodule

// File: tb/tb_md_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_ctrl -- self-checking bench for md_ctrl. Honours MD_DIV_EN the same way
// the design does, so one source covers both builds. Expected results come
// from a table of known answers and from an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_md_ctrl;
    import md_pkg::*;

    localparam int W = 32;
`ifdef MD_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    md_if #(.WIDTH(W)) bus ();

    md_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference HI/LO state
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Arithmetic reference: updates m_hi/m_lo, returns latency and illegal.
    function automatic void model_op(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output int lat,
                                     output logic ill);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ill = 1'b0;
        lat = W + 1;
        if (op == MD_MULT) begin
            p = 64'(sa * sb);
            {m_hi, m_lo} = p;
        end else if (op == MD_MULTU) begin
            p = {32'h0, a} * {32'h0, b};
            {m_hi, m_lo} = p;
        end else if (!DIV_EN) begin
            ill = 1'b1;
            lat = 0;
        end else if (b == 32'h0) begin
            m_lo = 32'hFFFF_FFFF;
            m_hi = a;
            lat  = 1;
        end else if (op == MD_DIV) begin
            q = sa / sb;
            r = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
        end else begin
            m_lo = a / b;
            m_hi = a % b;
        end
    endfunction

    // Issue one command (with a coinciding mthi/mtlo that must be dropped),
    // then follow it to done and compare latency, busy, illegal and HI/LO.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        int          exp_lat, lat, busy_cnt;
        logic        exp_ill;
        logic [31:0] pre_hi, pre_lo;
        pre_hi = m_hi;
        pre_lo = m_lo;
        model_op(op, a, b, exp_lat, exp_ill);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.a       = a;
        bus.b       = b;
        bus.wr_hi   = 1'b1;
        bus.wr_lo   = 1'b1;
        bus.wr_data = 32'hA5A5_0F0F;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        check({tag, " hold_at_accept"}, {bus.hi, bus.lo}, {pre_hi, pre_lo});
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 200) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, " illegal"}, 64'(bus.illegal), 64'(exp_ill));
        check({tag, " hi_lo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
    endtask

    // mthi/mtlo from an idle/done state.
    task automatic do_wr(input logic hi_en, input logic lo_en, input logic [31:0] data);
        @(negedge clk);
        bus.wr_hi   = hi_en;
        bus.wr_lo   = lo_en;
        bus.wr_data = data;
        @(posedge clk);
        #1;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        if (hi_en) m_hi = data;
        if (lo_en) m_lo = data;
        check("mt_hi_lo", {bus.hi, bus.lo}, {m_hi, m_lo});
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] exp_hl;
        int          lat, tmp_lat;
        logic        tmp_ill;

        vecs[0]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{MD_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[5]  = '{MD_MULT,  32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000};
        vecs[6]  = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[7]  = '{MD_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[8]  = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[10] = '{MD_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.a       = 32'h0;
        bus.b       = 32'h0;
        bus.wr_hi   = 1'b0;
        bus.wr_lo   = 1'b0;
        bus.wr_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset hi_lo", {bus.hi, bus.lo}, 64'h0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset illegal", 64'(bus.illegal), 64'd0);

        do_wr(1'b1, 1'b0, 32'h1234_5678);
        do_wr(1'b1, 1'b1, 32'h0BAD_F00D);

        // known-answer table
        for (int i = 0; i < 11; i++) begin
            exp_hl = (vecs[i].op[1] && !DIV_EN) ? {m_hi, m_lo}
                                                : {vecs[i].exp_hi, vecs[i].exp_lo};
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table", i), {bus.hi, bus.lo}, exp_hl);
        end

        // done/illegal are single-cycle pulses
        @(posedge clk);
        #1;
        check("done_pulse_end", 64'(bus.done), 64'd0);
        check("illegal_pulse_end", 64'(bus.illegal), 64'd0);

        // start and wr_lo while busy are ignored
        model_op(MD_MULTU, 32'd3, 32'd5, tmp_lat, tmp_ill);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 200) begin
            @(negedge clk);
            if (lat == 4) begin
                bus.start   = 1'b1;
                bus.op      = MD_MULT;
                bus.a       = 32'd7;
                bus.b       = 32'd7;
                bus.wr_lo   = 1'b1;
                bus.wr_hi   = 1'b1;
                bus.wr_data = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0;
                bus.wr_lo = 1'b0;
                bus.wr_hi = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wr_hi = 1'b0;
        check("busy_ignore latency", 64'(lat), 64'(W + 1));
        check("busy_ignore hi_lo", {bus.hi, bus.lo}, {m_hi, m_lo});

        // asynchronous reset in the middle of a multiply
        do_wr(1'b1, 1'b1, 32'h1357_9BDF);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst busy", 64'(bus.busy), 64'd0);
        check("async_rst done", 64'(bus.done), 64'd0);
        check("async_rst hi_lo", {bus.hi, bus.lo}, 64'h0);
        @(negedge clk);
        rst  = 1'b0;
        m_hi = 32'h0;
        m_lo = 32'h0;

        // randomized commands and idle writes against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(3, 0));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(7, 0))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(15, 0));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = 32'($urandom_range(255, 0));
                default: ;
            endcase
            do_op(rop, ra, rb, $sformatf("rnd%0d", i));
            if ($urandom_range(3, 0) == 0) begin
                do_wr(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
